// File: rtl/spi_write_controller.sv
// spi_write_controller: SPI mode-0 initiator that sends one 16-bit write frame
// {1'b1, addr[6:0], data[7:0]} MSB first per accepted start request.
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   start, addr, data  write request; addr/data latched on accept
//   busy, done, err  frame in progress, completion pulse, reject pulse
//   SCLK, COPI, nCS  SPI pins (SCLK idles low, nCS idles high)
module spi_write_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  localparam int unsigned CNT_W   = $clog2(CLK_DIV) + 1;
  localparam int unsigned FRAME_W = 16;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_BIT   = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    GUARD
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 sclk_q, sclk_d;
  logic                 copi_q, copi_d;
  logic                 ncs_q, ncs_d;
  logic                 in_frame;

  // State and registered pin/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
    end
  end

  // Next-state logic; pin values are derived from the next state so the
  // registered pins line up with the state register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (32'(addr) <= MAX_ADDR) begin
            shift_d = {1'b1, addr, data};
            bit_d   = '0;
            cnt_d   = CNT_RELOAD;
            state_d = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_RELOAD;
          state_d = SCLK_HI;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SCLK_HI: begin
        if (cnt_q == '0) begin
          // next bit presented on the falling edge; zero fill leaves COPI=0 after bit 16
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          cnt_d   = CNT_RELOAD;
          state_d = SCLK_LO;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SCLK_LO: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == LAST_BIT) begin
            state_d = GUARD;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = SCLK_HI;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GUARD: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    in_frame = (state_d == SETUP) || (state_d == SCLK_HI) || (state_d == SCLK_LO);
    busy_d   = (state_d != IDLE);
    ncs_d    = !in_frame;
    sclk_d   = (state_d == SCLK_HI);
    copi_d   = in_frame & shift_d[FRAME_W-1];
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign SCLK = sclk_q;
  assign COPI = copi_q;
  assign nCS  = ncs_q;

endmodule

// File: tb/tb_spi_write_controller.sv
// tb_spi_write_controller: directed bench for spi_write_controller with a
// CLK_DIV=4 instance (a) and a CLK_DIV=1 instance (b), each observed by a
// small SPI register-peripheral receiver model.
module tb_spi_write_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [6:0] addr_a = '0, addr_b = '0;
  logic [7:0] data_a = '0, data_b = '0;
  logic busy_a, done_a, err_a, sclk_a, copi_a, ncs_a;
  logic busy_b, done_b, err_b, sclk_b, copi_b, ncs_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_write_controller #(.CLK_DIV(4), .MAX_ADDR(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .addr(addr_a), .data(data_a),
    .busy(busy_a), .done(done_a), .err(err_a),
    .SCLK(sclk_a), .COPI(copi_a), .nCS(ncs_a)
  );

  spi_write_controller #(.CLK_DIV(1), .MAX_ADDR(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .addr(addr_b), .data(data_b),
    .busy(busy_b), .done(done_b), .err(err_b),
    .SCLK(sclk_b), .COPI(copi_b), .nCS(ncs_b)
  );

  // Receiver/monitor state for instance a
  int ncs_low_a = 0, busy_cnt_a = 0, done_cnt_a = 0, err_cnt_a = 0, rise_a = 0;
  int frames_a = 0, rx_n_a = 0, hi_run_a = 0, last_gap_a = 0;
  logic [15:0] rx_a = '0, last_frame_a = '0;
  logic prev_sclk_a = 1'b0, prev_ncs_a = 1'b1;
  logic [7:0] regs_a [0:127];

  // Receiver/monitor state for instance b
  int ncs_low_b = 0, busy_cnt_b = 0, done_cnt_b = 0, rise_b = 0, frames_b = 0, rx_n_b = 0;
  int cyc_b = 0, last_rise_cyc_b = -1, last_period_b = 0;
  logic [15:0] rx_b = '0, last_frame_b = '0;
  logic prev_sclk_b = 1'b0, prev_ncs_b = 1'b1;

  always @(negedge clk) begin
    if (!ncs_a) ncs_low_a++;
    if (busy_a) busy_cnt_a++;
    if (done_a) done_cnt_a++;
    if (err_a)  err_cnt_a++;
    if (!ncs_a && prev_ncs_a) rx_n_a = 0;
    if (sclk_a && !prev_sclk_a && !ncs_a) begin
      rx_a = {rx_a[14:0], copi_a};
      rx_n_a++;
      rise_a++;
    end
    if (ncs_a && !prev_ncs_a && rx_n_a == 16 && rx_a[15]) begin
      regs_a[rx_a[14:8]] = rx_a[7:0];
      last_frame_a = rx_a;
      frames_a++;
    end
    if (ncs_a) hi_run_a++;
    else begin
      if (prev_ncs_a) last_gap_a = hi_run_a;
      hi_run_a = 0;
    end
    prev_sclk_a = sclk_a;
    prev_ncs_a  = ncs_a;
  end

  always @(negedge clk) begin
    cyc_b++;
    if (!ncs_b) ncs_low_b++;
    if (busy_b) busy_cnt_b++;
    if (done_b) done_cnt_b++;
    if (!ncs_b && prev_ncs_b) rx_n_b = 0;
    if (sclk_b && !prev_sclk_b && !ncs_b) begin
      rx_b = {rx_b[14:0], copi_b};
      rx_n_b++;
      rise_b++;
      if (last_rise_cyc_b >= 0) last_period_b = cyc_b - last_rise_cyc_b;
      last_rise_cyc_b = cyc_b;
    end
    if (ncs_b && !prev_ncs_b && rx_n_b == 16) begin
      last_frame_b = rx_b;
      frames_b++;
    end
    prev_sclk_b = sclk_b;
    prev_ncs_b  = ncs_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts cycles after the accepting edge until done is seen (bounded)
  task automatic wait_done(input bit sel_b, input string tag, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (sel_b ? done_b : done_a) return;
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send_a(input logic [6:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    start_a = 1'b1; addr_a = a; data_a = d;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  int n, s_ncs, s_busy, s_done, s_err, s_rise, s_frames;

  task automatic snap_a();
    s_ncs = ncs_low_a; s_busy = busy_cnt_a; s_done = done_cnt_a;
    s_err = err_cnt_a; s_rise = rise_a; s_frames = frames_a;
  endtask

  initial begin
    // Reset values
    #12;
    check("reset_pins_a", 32'({ncs_a, sclk_a, copi_a, busy_a, done_a, err_a}), 32'b100000);
    check("reset_pins_b", 32'({ncs_b, sclk_b, copi_b, busy_b, done_b, err_b}), 32'b100000);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame addr=2 data=0x3C
    snap_a();
    send_a(7'h02, 8'h3C);
    wait_done(1'b0, "f1", 300, n);
    check("f1_done_latency", 32'(n), 32'd137);
    repeat (5) @(negedge clk);
    check("f1_copi_bits", 32'(last_frame_a), 32'h823C);
    check("f1_ncs_low", 32'(ncs_low_a - s_ncs), 32'd132);
    check("f1_busy", 32'(busy_cnt_a - s_busy), 32'd136);
    check("f1_done_pulses", 32'(done_cnt_a - s_done), 32'd1);
    check("f1_sclk_rises", 32'(rise_a - s_rise), 32'd16);
    check("f1_reg2", 32'(regs_a[2]), 32'h3C);

    // Rejected address
    snap_a();
    send_a(7'h05, 8'h11);
    repeat (10) @(negedge clk);
    check("rej_err_pulses", 32'(err_cnt_a - s_err), 32'd1);
    check("rej_ncs_low", 32'(ncs_low_a - s_ncs), 32'd0);
    check("rej_busy", 32'(busy_cnt_a - s_busy), 32'd0);
    check("rej_done", 32'(done_cnt_a - s_done), 32'd0);
    check("rej_sclk", 32'(rise_a - s_rise), 32'd0);

    // Back-to-back frames with start held high
    snap_a();
    @(posedge clk); #1;
    start_a = 1'b1; addr_a = 7'h01; data_a = 8'hA5;
    @(posedge clk); #1;
    addr_a = 7'h03; data_a = 8'h5A;
    wait_done(1'b0, "b2b1", 300, n);
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(1'b0, "b2b2", 300, n);
    repeat (5) @(negedge clk);
    check("b2b_frames", 32'(frames_a - s_frames), 32'd2);
    check("b2b_gap", 32'(last_gap_a), 32'd5);
    check("b2b_reg1", 32'(regs_a[1]), 32'hA5);
    check("b2b_reg3", 32'(regs_a[3]), 32'h5A);
    check("b2b_done", 32'(done_cnt_a - s_done), 32'd2);

    // start while busy is ignored
    snap_a();
    send_a(7'h00, 8'h42);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    start_a = 1'b1; addr_a = 7'h04; data_a = 8'hFF;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(1'b0, "busy_ign", 300, n);
    repeat (160) @(negedge clk);
    check("busy_ign_frames", 32'(frames_a - s_frames), 32'd1);
    check("busy_ign_frame", 32'(last_frame_a), 32'h8042);
    check("busy_ign_busy", 32'(busy_cnt_a - s_busy), 32'd136);
    check("busy_ign_reg0", 32'(regs_a[0]), 32'h42);

    // Reset after the 8th SCLK rising edge
    snap_a();
    send_a(7'h03, 8'h77);
    n = 0;
    while ((rise_a - s_rise) < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_8", 32'(rise_a - s_rise), 32'd8);
    #2 rst = 1'b1;
    #1;
    check("rst_async_pins", 32'({ncs_a, sclk_a, busy_a}), 32'b100);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rst_no_done", 32'(done_cnt_a - s_done), 32'd0);
    check("rst_no_frame", 32'(frames_a - s_frames), 32'd0);
    check("rst_reg3_kept", 32'(regs_a[3]), 32'h5A);
    snap_a();
    send_a(7'h00, 8'h81);
    wait_done(1'b0, "post_rst", 300, n);
    repeat (3) @(negedge clk);
    check("post_rst_latency", 32'(n), 32'd137);
    check("post_rst_frame", 32'(last_frame_a), 32'h8081);
    check("post_rst_reg0", 32'(regs_a[0]), 32'h81);

    // CLK_DIV=1 instance
    s_ncs = ncs_low_b; s_busy = busy_cnt_b; s_rise = rise_b;
    @(posedge clk); #1;
    start_b = 1'b1; addr_b = 7'h04; data_b = 8'hFF;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_done(1'b1, "div1", 100, n);
    repeat (3) @(negedge clk);
    check("div1_done_latency", 32'(n), 32'd35);
    check("div1_busy", 32'(busy_cnt_b - s_busy), 32'd34);
    check("div1_ncs_low", 32'(ncs_low_b - s_ncs), 32'd33);
    check("div1_rises", 32'(rise_b - s_rise), 32'd16);
    check("div1_period", 32'(last_period_b), 32'd2);
    check("div1_frame", 32'(last_frame_b), 32'h84FF);
    check("div1_frames", 32'(frames_b), 32'd1);
    check("done_cnt_b", 32'(done_cnt_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_write_controller.md
Name: spi_write_controller

Overview:
- SPI initiator that generates write frames for the on-chip SPI register peripheral, driving SCLK, nCS and COPI from the system clock.
- A single start request sends one 16-bit write frame: R/W bit = 1, 7-bit address, 8-bit data, MSB first, SPI mode 0.
- Sits in the test/bring-up harness and drives the peripheral's pins so that its five 8-bit registers can be loaded on-chip.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range is 1 and up.
- MAX_ADDR, 4, highest address accepted; higher addresses are rejected without a frame.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request one write frame; sampled only when busy=0
- addr  input  7  register address, latched on accept
- data  input  8  register data, latched on accept
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame completion
- err  output  1  one-cycle pulse when a start is rejected (addr > MAX_ADDR)
- SCLK  output  1  SPI clock, idles low
- COPI  output  1  serial data to peripheral
- nCS  output  1  chip select, active low, idles high

Behaviour:
- Reset values, applied asynchronously on rst=1: nCS=1, SCLK=0, COPI=0, busy=0, done=0, err=0. The state machine returns to IDLE and all counters clear.
- Reset mid-frame aborts the frame immediately, with nCS going high. There is no resume and no done pulse.
- All outputs are registered, so there are no combinational paths from inputs to outputs.
- States: IDLE, SETUP, SCLK_HI, SCLK_LO, GUARD.
- IDLE:
  - On a clk edge with start=1 and addr<=MAX_ADDR, latch shift register {1'b1, addr, data}, go to SETUP, set busy=1, nCS=0, COPI=frame[15].
  - On start=1 and addr>MAX_ADDR, pulse err for exactly one cycle (the next cycle). The state stays IDLE, busy stays 0, and the pins do not toggle.
- SETUP: hold for CLK_DIV cycles with SCLK=0 (COPI setup before the first rising edge), then go to SCLK_HI.
- SCLK_HI: SCLK=1 for CLK_DIV cycles; the peripheral samples COPI on the rising edge. Then go to SCLK_LO.
- SCLK_LO:
  - SCLK=0 for CLK_DIV cycles.
  - COPI updates to the next bit in the same cycle SCLK falls.
  - After the 16th bit, COPI=0.
  - 4-bit bit counter: if fewer than 16 bits have been sent, go to SCLK_HI; else set nCS=1 and go to GUARD. The last low phase is the nCS hold time.
- GUARD: nCS=1, SCLK=0 for CLK_DIV cycles, then go to IDLE with busy=0 and done=1 for one cycle.
- Back-to-back frames: start is sampled in the same cycle done is high, so back-to-back frames are possible. nCS stays high for exactly CLK_DIV+1 cycles between frames.
- start while busy=1 is ignored; the latched addr/data are unaffected by input changes during a frame.
- Frame timing (accept on edge t0):
  - busy=1 for cycles t0+1 through t0+34*CLK_DIV.
  - nCS=0 for the first 33*CLK_DIV of those cycles.
  - Exactly 16 SCLK rising edges per frame.
  - done high at cycle t0+34*CLK_DIV+1.
- Division counter width is clog2(CLK_DIV)+1. It reloads on every state entry and does not free-run.
- done and err are never high in the same cycle.

Test Plan:
- CLK_DIV=4, addr=0x02, data=0x3C, looped into the SPI peripheral:
  - COPI sampled at the 16 SCLK rising edges is 1,0000010,00111100.
  - nCS is low for 132 cycles; busy is high for 136 cycles; done pulses once.
  - Peripheral addr2 reads 0x3C.
- MAX_ADDR=4, start with addr=0x05:
  - err pulses for 1 cycle.
  - nCS stays 1, SCLK stays 0, busy stays 0, and no done pulse occurs.
- start held high with addr=1/data=0xA5, then addr=3/data=0x5A:
  - Two frames are sent back-to-back, with nCS high for exactly 5 cycles between them.
  - Peripheral addr1=0xA5 and addr3=0x5A.
- start pulsed mid-frame with addr=4/data=0xFF while busy: the frame in flight still carries the original addr/data, and no second frame is sent.
- rst asserted after the 8th SCLK rising edge:
  - nCS=1 and SCLK=0 in the same cycle, asynchronously; busy=0; no done pulse.
  - A subsequent start with addr=0/data=0x81 produces a complete, correct frame.
- CLK_DIV=1, addr=4, data=0xFF:
  - SCLK period is 2 cycles; busy is high for 34 cycles.
  - COPI pattern is 1,0000100,11111111.
